// File: rtl/hilo_ctrl.sv
// HI/LO register control for the EX stage: issues multiplies to an external
// multiplier, stalls until completion, and handles MTHI/MTLO and multiply-accumulate.
module hilo_ctrl (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_signed,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_MTHI  = 3'b011,
    OP_MTLO  = 3'b100,
    OP_MADD  = 3'b101,
    OP_MADDU = 3'b110,
    OP_RSVD  = 3'b111
  } op_t;

  state_t state;
  logic   acc_op;
  logic   mul_class;
  logic   issue;

  always_comb begin
    mul_class = 1'b0;
    case (op_t'(op_code))
      OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: mul_class = 1'b1;
      default:                              mul_class = 1'b0;
    endcase
  end

  // issue ignores reset; the outputs additionally gate on cpu_rstn
  assign issue      = (state == IDLE) && op_valid && !flush && mul_class;
  assign mul_start  = cpu_rstn && issue;
  assign mul_a      = src_a;
  assign mul_b      = src_b;
  assign mul_signed = (op_code == OP_MULT) || (op_code == OP_MADD);
  assign stall      = cpu_rstn &&
                      (issue || ((state == WAIT) && !mul_done && !flush));

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state  <= IDLE;
      acc_op <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state  <= WAIT;
            acc_op <= (op_code == OP_MADD) || (op_code == OP_MADDU);
          end else if (op_valid && !flush) begin
            if (op_code == OP_MTHI) hi <= src_a;
            if (op_code == OP_MTLO) lo <= src_a;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (mul_done) begin
            state <= IDLE;
            if (acc_op) {hi, lo} <= {hi, lo} + mul_result;
            else        {hi, lo} <= mul_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed self-checking bench for hilo_ctrl; the bench plays the multiplier
// using hand-computed products.
module tb_hilo_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic        mul_signed;
  logic        mul_done;
  logic [63:0] mul_result;
  logic        stall;
  logic [31:0] hi, lo;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  hilo_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .op_valid(op_valid), .op_code(op_code),
    .src_a(src_a), .src_b(src_b), .flush(flush), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed), .mul_done(mul_done),
    .mul_result(mul_result), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 1'b0; op_code = 3'b000; src_a = '0; src_b = '0;
    flush = 1'b0; mul_done = 1'b0; mul_result = '0;
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    idle_inputs();
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd5; src_b = 32'd7;
    #1;
    total_cnt++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start got %0b want 0", mul_start); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else pass_cnt++;
    cyc(); cyc();
    total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else pass_cnt++;
    idle_inputs();
    cpu_rstn = 1'b1;
    cyc();
  endtask

  task automatic test_mult();
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'hFFFFFFFE; src_b = 32'h00000003;
    #1;
    total_cnt++; if (mul_start !== 1'b1) $display("FAIL mult_start got %0b want 1", mul_start); else pass_cnt++;
    total_cnt++; if (mul_signed !== 1'b1) $display("FAIL mult_signed got %0b want 1", mul_signed); else pass_cnt++;
    total_cnt++; if (stall !== 1'b1) $display("FAIL mult_stall_accept got %0b want 1", stall); else pass_cnt++;
    total_cnt++; if ({mul_a, mul_b} !== {32'hFFFFFFFE, 32'h00000003})
      $display("FAIL mult_operands got %h %h want fffffffe 00000003", mul_a, mul_b); else pass_cnt++;
    cyc();
    // same op still presented during the done cycle must not be reissued
    mul_done = 1'b1; mul_result = 64'hFFFFFFFF_FFFFFFFA;
    #1;
    total_cnt++; if (mul_start !== 1'b0) $display("FAIL mult_no_reissue got %0b want 0", mul_start); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL mult_stall_done got %0b want 0", stall); else pass_cnt++;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA)
      $display("FAIL mult_result got %h want fffffffffffffffa", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_multu();
    op_valid = 1'b1; op_code = 3'b010; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    #1;
    total_cnt++; if (mul_signed !== 1'b0) $display("FAIL multu_signed got %0b want 0", mul_signed); else pass_cnt++;
    total_cnt++; if (mul_start !== 1'b1) $display("FAIL multu_start got %0b want 1", mul_start); else pass_cnt++;
    cyc();
    op_valid = 1'b0; mul_done = 1'b1; mul_result = 64'hFFFFFFFE_00000001;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi got %h want fffffffe", hi); else pass_cnt++;
    total_cnt++; if (lo !== 32'h00000001) $display("FAIL multu_lo got %h want 00000001", lo); else pass_cnt++;
  endtask

  task automatic test_mthi_mtlo_madd();
    op_valid = 1'b1; op_code = 3'b011; src_a = 32'h12345678;
    #1;
    total_cnt++; if ({mul_start, stall} !== 2'b00) $display("FAIL mthi_no_stall got %b want 00", {mul_start, stall}); else pass_cnt++;
    cyc();
    op_code = 3'b100; src_a = 32'h00000001;
    cyc();
    // NOP and reserved codes must leave hi/lo alone
    op_code = 3'b000; src_a = 32'hDEADBEEF;
    cyc();
    op_code = 3'b111;
    cyc();
    total_cnt++; if ({hi, lo} !== 64'h12345678_00000001)
      $display("FAIL mthi_mtlo got %h want 1234567800000001", {hi, lo}); else pass_cnt++;
    op_code = 3'b101; src_a = 32'd2; src_b = 32'd3;
    #1;
    total_cnt++; if ({mul_start, mul_signed} !== 2'b11) $display("FAIL madd_start got %b want 11", {mul_start, mul_signed}); else pass_cnt++;
    cyc();
    op_valid = 1'b0; mul_done = 1'b1; mul_result = 64'd6;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'h12345678_00000007)
      $display("FAIL madd_result got %h want 1234567800000007", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_maddu_wrap();
    op_valid = 1'b1; op_code = 3'b011; src_a = 32'hFFFFFFFF;
    cyc();
    op_code = 3'b100;
    cyc();
    op_code = 3'b110; src_a = 32'd1; src_b = 32'd1;
    #1;
    total_cnt++; if ({mul_start, mul_signed} !== 2'b10) $display("FAIL maddu_start got %b want 10", {mul_start, mul_signed}); else pass_cnt++;
    cyc();
    op_valid = 1'b0; mul_done = 1'b1; mul_result = 64'd1;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL maddu_wrap got %h want 0", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_flush();
    op_valid = 1'b1; op_code = 3'b011; src_a = 32'hA5A5A5A5;
    cyc();
    op_code = 3'b100; src_a = 32'h5A5A5A5A;
    cyc();
    // flush in IDLE suppresses both multiply issue and MTHI
    op_code = 3'b001; src_a = 32'd9; src_b = 32'd9; flush = 1'b1;
    #1;
    total_cnt++; if ({mul_start, stall} !== 2'b00) $display("FAIL flush_idle got %b want 00", {mul_start, stall}); else pass_cnt++;
    cyc();
    op_code = 3'b011; src_a = 32'h11111111;
    cyc();
    flush = 1'b0; op_code = 3'b001; src_a = 32'd4; src_b = 32'd4;
    #1;
    total_cnt++; if (mul_start !== 1'b1) $display("FAIL flush_accept got %0b want 1", mul_start); else pass_cnt++;
    cyc();
    op_valid = 1'b0; mul_done = 1'b1; mul_result = 64'd16; flush = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL flush_done_stall got %0b want 0", stall); else pass_cnt++;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'hA5A5A5A5_5A5A5A5A)
      $display("FAIL flush_hilo got %h want a5a5a5a55a5a5a5a", {hi, lo}); else pass_cnt++;
    // back in IDLE: a stray mul_done is ignored and a new op is accepted
    mul_done = 1'b1; mul_result = 64'hFFFF;
    op_valid = 1'b1; op_code = 3'b010; src_a = 32'd1; src_b = 32'd1;
    #1;
    total_cnt++; if ({mul_start, stall} !== 2'b11) $display("FAIL flush_back_idle got %b want 11", {mul_start, stall}); else pass_cnt++;
    cyc();
    flush = 1'b1; op_valid = 1'b0; mul_done = 1'b0;
    cyc();
    idle_inputs();
    mul_done = 1'b1; mul_result = 64'hFFFF;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'hA5A5A5A5_5A5A5A5A)
      $display("FAIL stray_done got %h want a5a5a5a55a5a5a5a", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_long_wait();
    int unsigned stall_cycles = 0;
    int unsigned starts = 0;
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd3; src_b = 32'd5;
    for (int i = 0; i < 20; i++) begin
      mul_done = (i == 6);
      mul_result = 64'd15;
      #1;
      if (stall) stall_cycles++;
      if (mul_start) starts++;
      cyc();
      if (i == 6) break;
    end
    idle_inputs();
    #1;
    total_cnt++; if (stall_cycles != 6) $display("FAIL long_stall_cycles got %0d want 6", stall_cycles); else pass_cnt++;
    total_cnt++; if (starts != 1) $display("FAIL long_start_pulses got %0d want 1", starts); else pass_cnt++;
    total_cnt++; if ({hi, lo} !== 64'd15) $display("FAIL long_result got %h want f", {hi, lo}); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    op_valid = 1'b1; op_code = 3'b001; src_a = 32'd7; src_b = 32'd7;
    cyc();
    idle_inputs();
    cpu_rstn = 1'b0;
    #1;
    total_cnt++; if ({mul_start, stall} !== 2'b00) $display("FAIL rst_wait_outputs got %b want 00", {mul_start, stall}); else pass_cnt++;
    cyc();
    cpu_rstn = 1'b1; mul_done = 1'b1; mul_result = 64'd49;
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_late_done_stall got %0b want 0", stall); else pass_cnt++;
    cyc();
    idle_inputs();
    #1;
    total_cnt++; if ({hi, lo} !== 64'h0) $display("FAIL rst_late_done_hilo got %h want 0", {hi, lo}); else pass_cnt++;
  endtask

  initial begin
    cpu_rstn = 1'b0;
    idle_inputs();
    cyc();
    test_reset();
    test_mult();
    test_multu();
    test_mthi_mtlo_madd();
    test_maddu_wrap();
    test_flush();
    test_long_wait();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
